// File: rtl/core_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : core_fetch_unit                                               |
// | Purpose  : Instruction fetch front-end. Generates sequential fetch PCs,  |
// |            issues word requests to instruction memory, buffers in-order  |
// |            responses with their PCs in a small FIFO and presents them to |
// |            decode over a valid/ready handshake. A redirect flushes the   |
// |            buffer and discards responses still in flight.                |
// | Ports    : clk, rst_n            - clock, async active-low reset         |
// |            imem_req_*            - fetch request (valid/ready, addr)     |
// |            imem_rsp_*            - in-order fetch response (valid, data) |
// |            redirect_*            - change of flow (valid, pc)            |
// |            inst_*                - decode handshake (valid/ready, data,  |
// |                                    pc, opcode)                           |
// |            perf_fetched/stall    - optional performance counters         |
// | Config   : FETCH_PERF_EN - when defined, adds saturating counters of     |
// |            instructions popped and ready-but-starved cycles.             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module core_fetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  // instruction memory request
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  // instruction memory response (in request order)
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  // change of flow
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  // decode handshake
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic [6:0]      inst_opcode
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall
`endif
);

  // Pointer and counter widths. Counters must reach FIFO_DEPTH itself.
  localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W:0]   c_DEPTH_EXT = (c_CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [XLEN-1:0]    c_PC_STEP   = XLEN'(4);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic                r_active;     // low during reset, high from first edge after
  logic [XLEN-1:0]     r_fetch_pc;
  logic [c_CNT_W-1:0]  r_out_cnt;    // requests accepted but not yet answered
  logic [c_CNT_W-1:0]  r_drop;       // responses still to be discarded

  // instruction buffer: word + PC per entry
  logic [XLEN-1:0]     r_inst_mem [FIFO_DEPTH];
  logic [XLEN-1:0]     r_ipc_mem  [FIFO_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;

  // PC queue: addresses of requests whose responses will be kept
  logic [XLEN-1:0]     r_pcq_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]  r_pcq_wr;
  logic [c_PTR_W-1:0]  r_pcq_rd;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic                w_credit;
  logic                w_req_fire;
  logic                w_rsp_keep;
  logic                w_rsp_discard;
  logic                w_pop;
  logic [c_CNT_W-1:0]  w_out_next;
  logic [XLEN-1:0]     w_redirect_pc;
  logic                w_unused_redirect_lsbs;

  // Credit check: every buffered entry plus every in-flight request owns a
  // FIFO slot, so a response can always be written without back-pressure.
  assign w_credit = (({1'b0, r_count} + {1'b0, r_out_cnt}) < c_DEPTH_EXT);

  assign imem_req_valid = r_active & ~redirect_valid & w_credit;
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid & imem_req_ready;

  // A response in a redirect cycle belongs to the old flow and is discarded;
  // it is folded into the drop count through w_out_next below.
  assign w_rsp_keep    = imem_rsp_valid & ~redirect_valid & (r_drop == '0);
  assign w_rsp_discard = imem_rsp_valid & ~redirect_valid & (r_drop != '0);

  assign w_pop = inst_valid & inst_ready;

  always_comb begin
    w_out_next = r_out_cnt;
    unique case ({w_req_fire, imem_rsp_valid})
      2'b10:   w_out_next = r_out_cnt + c_CNT_ONE;
      2'b01:   w_out_next = r_out_cnt - c_CNT_ONE;
      default: w_out_next = r_out_cnt;
    endcase
  end

  assign w_redirect_pc          = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_unused_redirect_lsbs = ^redirect_pc[1:0];

  // --------------------------------------------------------------------------
  // Fetch PC, outstanding and drop accounting
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active   <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_out_cnt  <= '0;
      r_drop     <= '0;
    end else begin
      r_active  <= 1'b1;
      r_out_cnt <= w_out_next;
      if (redirect_valid) begin
        r_fetch_pc <= w_redirect_pc;
        // Everything still in flight after this cycle belongs to the old flow.
        r_drop     <= w_out_next;
      end else begin
        if (w_req_fire) begin
          r_fetch_pc <= r_fetch_pc + c_PC_STEP;
        end
        if (w_rsp_discard) begin
          r_drop <= r_drop - c_CNT_ONE;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // PC queue pointers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcq_wr <= '0;
      r_pcq_rd <= '0;
    end else if (redirect_valid) begin
      r_pcq_wr <= '0;
      r_pcq_rd <= '0;
    end else begin
      if (w_req_fire) begin
        r_pcq_wr <= r_pcq_wr + c_PTR_W'(1);
      end
      if (w_rsp_keep) begin
        r_pcq_rd <= r_pcq_rd + c_PTR_W'(1);
      end
    end
  end

  // PC queue storage needs no reset: an entry is only read after being written.
  always_ff @(posedge clk) begin
    if (w_req_fire) begin
      r_pcq_mem[r_pcq_wr] <= r_fetch_pc;
    end
  end

  // --------------------------------------------------------------------------
  // Instruction buffer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      // A coinciding pop is simply absorbed by the flush.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_rsp_keep) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      unique case ({w_rsp_keep, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // A response is never the same cycle as its request (latency >= 1), so the
  // PC queue head is already valid when the word is written.
  always_ff @(posedge clk) begin
    if (w_rsp_keep) begin
      r_inst_mem[r_wr_ptr] <= imem_rsp_data;
      r_ipc_mem[r_wr_ptr]  <= r_pcq_mem[r_pcq_rd];
    end
  end

  // --------------------------------------------------------------------------
  // Decode-side outputs: registered head, forced to zero while empty so the
  // outputs are defined from reset without resetting the storage arrays.
  // --------------------------------------------------------------------------
  assign inst_valid  = (r_count != '0);
  assign inst_data   = inst_valid ? r_inst_mem[r_rd_ptr] : '0;
  assign inst_pc     = inst_valid ? r_ipc_mem[r_rd_ptr]  : '0;
  assign inst_opcode = inst_data[6:0];

`ifdef FETCH_PERF_EN
  // --------------------------------------------------------------------------
  // Performance counters: saturating, untouched by redirect.
  // --------------------------------------------------------------------------
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_pop && (r_perf_fetched != 32'hFFFF_FFFF)) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (inst_ready && !inst_valid && (r_perf_stall != 32'hFFFF_FFFF)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_core_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_core_fetch_unit                                            |
// | Purpose  : Directed self-checking bench for core_fetch_unit. A memory    |
// |            model answers each request with ~addr after a programmable   |
// |            latency, so every instruction word is known from its PC.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_core_fetch_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready = 1'b0;
  logic            imem_rsp_valid = 1'b0;
  logic [XLEN-1:0] imem_rsp_data = '0;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            inst_valid;
  logic            inst_ready = 1'b0;
  logic [XLEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;
  logic [6:0]      inst_opcode;
`ifdef FETCH_PERF_EN
  logic [31:0]     perf_fetched;
  logic [31:0]     perf_stall;
`endif

  core_fetch_unit #(.XLEN(XLEN), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_opcode    (inst_opcode)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int lat          = 1;
  int acc_cnt      = 0;

  typedef struct {
    logic [XLEN-1:0] addr;
    int              due;
  } req_t;
  req_t mq[$];

  // Memory model: record accepted requests on the active edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      mq.delete();
    end else if (imem_req_valid && imem_req_ready) begin
      mq.push_back('{addr: imem_req_addr, due: cyc + lat});
      acc_cnt = acc_cnt + 1;
    end
  end

  // Memory model: present the response for the coming edge, in order.
  always @(negedge clk) begin
    if (!rst_n) begin
      imem_rsp_valid = 1'b0;
    end else if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = ~mq[0].addr;
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
    end
  end

  task automatic do_reset(input int latency);
    @(negedge clk);
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    lat            = latency;
    repeat (2) @(negedge clk);
    acc_cnt = 0;
    rst_n   = 1'b1;
  endtask

  // Called at a negedge: finds the next cycle where a pop will happen,
  // captures the head, and returns one negedge later (after the pop edge).
  task automatic wait_pop(output logic [XLEN-1:0] pc, output logic [XLEN-1:0] data,
                          output logic [6:0] op, output bit ok);
    ok = 1'b0; pc = '0; data = '0; op = '0;
    for (int i = 0; i < 40; i++) begin
      if (inst_valid && inst_ready) begin
        pc = inst_pc; data = inst_data; op = inst_opcode; ok = 1'b1;
      end
      @(negedge clk);
      if (ok) break;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    tests_run++;
    if (imem_req_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid);
    end
    tests_run++;
    if (imem_req_addr !== 32'h0) begin
      tests_failed++; $display("FAIL reset_req_addr: got %h want 00000000", imem_req_addr);
    end
    tests_run++;
    if (inst_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid);
    end
    tests_run++;
    if (inst_data !== 32'h0 || inst_pc !== 32'h0) begin
      tests_failed++; $display("FAIL reset_inst_outputs: got data=%h pc=%h want 0/0", inst_data, inst_pc);
    end
  endtask

  task automatic test_sequential;
    logic [XLEN-1:0] pc, data, exp;
    logic [6:0] op;
    bit ok;
    do_reset(1);
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp = 32'(i * 4);
      wait_pop(pc, data, op, ok);
      tests_run++;
      if (!ok || pc !== exp || data !== ~exp || op !== ~exp[6:0]) begin
        tests_failed++;
        $display("FAIL seq_pop%0d: got ok=%0d pc=%h data=%h op=%h want pc=%h data=%h op=%h",
                 i, ok, pc, data, op, exp, ~exp, ~exp[6:0]);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [XLEN-1:0] pc, data, exp;
    logic [6:0] op;
    bit ok;
    do_reset(1);
    imem_req_ready = 1'b1;
    inst_ready     = 1'b0;
    repeat (12) @(negedge clk);
    tests_run++;
    if (acc_cnt !== 4) begin
      tests_failed++; $display("FAIL bp_accept_count: got %0d want 4", acc_cnt);
    end
    tests_run++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
      tests_failed++;
      $display("FAIL bp_full_state: got req_valid=%b inst_valid=%b pc=%h want 0/1/00000000",
               imem_req_valid, inst_valid, inst_pc);
    end
    inst_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp = 32'(i * 4);
      wait_pop(pc, data, op, ok);
      tests_run++;
      if (!ok || pc !== exp || data !== ~exp) begin
        tests_failed++;
        $display("FAIL bp_pop%0d: got ok=%0d pc=%h data=%h want pc=%h data=%h", i, ok, pc, data, exp, ~exp);
      end
    end
  endtask

  task automatic test_redirect;
    logic [XLEN-1:0] pc, data;
    logic [6:0] op;
    bit ok;
    do_reset(3);
    inst_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (acc_cnt >= 2) break;
    end
    imem_req_ready = 1'b0;
    tests_run++;
    if (acc_cnt !== 2 || inst_valid !== 1'b0) begin
      tests_failed++; $display("FAIL redir_setup: got accepts=%0d inst_valid=%b want 2/0", acc_cnt, inst_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    @(negedge clk);
    redirect_valid = 1'b0;
    tests_run++;
    if (imem_req_addr !== 32'h0000_0100 || inst_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL redir_addr: got addr=%h inst_valid=%b want 00000100/0", imem_req_addr, inst_valid);
    end
    imem_req_ready = 1'b1;
    wait_pop(pc, data, op, ok);
    tests_run++;
    if (!ok || pc !== 32'h0000_0100 || data !== ~32'h0000_0100) begin
      tests_failed++;
      $display("FAIL redir_first_pop: got ok=%0d pc=%h data=%h want pc=00000100 data=%h",
               ok, pc, data, ~32'h0000_0100);
    end
  endtask

  task automatic test_req_stall;
    logic [XLEN-1:0] pc, data;
    logic [6:0] op;
    bit ok;
    do_reset(1);
    inst_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 || inst_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_cycle%0d: got valid=%b addr=%h inst_valid=%b want 1/00000000/0",
                 i, imem_req_valid, imem_req_addr, inst_valid);
      end
    end
    tests_run++;
    if (acc_cnt !== 0) begin
      tests_failed++; $display("FAIL stall_no_accept: got %0d want 0", acc_cnt);
    end
    imem_req_ready = 1'b1;
    wait_pop(pc, data, op, ok);
    tests_run++;
    if (!ok || pc !== 32'h0 || data !== ~32'h0) begin
      tests_failed++; $display("FAIL stall_resume: got ok=%0d pc=%h data=%h want pc=00000000 data=ffffffff", ok, pc, data);
    end
  endtask

  task automatic test_redirect_collision;
    logic [XLEN-1:0] pc, data;
    logic [6:0] op;
    bit ok;
    do_reset(1);
    @(negedge clk);
    imem_req_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (acc_cnt >= 2) break;
    end
    imem_req_ready = 1'b0;
    tests_run++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || imem_rsp_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL coll_setup: got inst_valid=%b pc=%h rsp_valid=%b want 1/00000000/1",
               inst_valid, inst_pc, imem_rsp_valid);
    end
    // response, pop and redirect all land on the same edge
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    @(negedge clk);
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    tests_run++;
    if (inst_valid !== 1'b0 || imem_req_addr !== 32'h0000_0200) begin
      tests_failed++;
      $display("FAIL coll_flush: got inst_valid=%b addr=%h want 0/00000200", inst_valid, imem_req_addr);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (inst_valid !== 1'b0) begin
      tests_failed++; $display("FAIL coll_stays_empty: got inst_valid=%b want 0", inst_valid);
    end
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    wait_pop(pc, data, op, ok);
    tests_run++;
    if (!ok || pc !== 32'h0000_0200 || data !== ~32'h0000_0200) begin
      tests_failed++;
      $display("FAIL coll_next_pop: got ok=%0d pc=%h data=%h want pc=00000200 data=%h", ok, pc, data, ~32'h0000_0200);
    end
  endtask

  task automatic test_back_to_back;
    logic [XLEN-1:0] pc, data, exp;
    logic [6:0] op;
    bit ok;
    do_reset(3);
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    repeat (6) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    @(negedge clk);
    redirect_pc    = 32'h0000_0402;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp = 32'h0000_0400 + 32'(i * 4);
      wait_pop(pc, data, op, ok);
      tests_run++;
      if (!ok || pc !== exp || data !== ~exp) begin
        tests_failed++;
        $display("FAIL b2b_pop%0d: got ok=%0d pc=%h data=%h want pc=%h data=%h", i, ok, pc, data, exp, ~exp);
      end
    end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf;
    int pops;
    do_reset(1);
    inst_ready = 1'b1;
    repeat (3) @(negedge clk);
    inst_ready     = 1'b0;
    imem_req_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 200 && pops < 10; i++) begin
      inst_ready = inst_valid;
      if (inst_valid) pops++;
      @(negedge clk);
    end
    inst_ready = 1'b0;
    @(negedge clk);
    tests_run++;
    if (perf_fetched !== 32'd10) begin
      tests_failed++; $display("FAIL perf_fetched: got %0d want 10", perf_fetched);
    end
    tests_run++;
    if (perf_stall !== 32'd3) begin
      tests_failed++; $display("FAIL perf_stall: got %0d want 3", perf_stall);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_req_stall();
    test_redirect_collision();
    test_back_to_back();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
